// File: rtl/psum_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lenet_acc_pkg
// Brief   : Shared widths, saturation bounds and the round/ReLU/saturate helper
// Revision: 1.0 - initial release
// ============================================================================
package lenet_acc_pkg;

    localparam int DEF_DATA_WIDTH = 22;
    localparam int DEF_PORT_WIDTH = 9;
    localparam int SHIFT_WIDTH    = 5;

    localparam logic signed [DEF_DATA_WIDTH:0] SAT_MAX =
        (DEF_DATA_WIDTH+1)'((2 ** (DEF_PORT_WIDTH-1)) - 1);
    localparam logic signed [DEF_DATA_WIDTH:0] SAT_MIN =
        (DEF_DATA_WIDTH+1)'(-(2 ** (DEF_PORT_WIDTH-1)));

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic signed [DEF_PORT_WIDTH-1:0] sat_round(
        input logic signed [DEF_DATA_WIDTH-1:0] psum,
        input logic        [SHIFT_WIDTH-1:0]    shift,
        input logic                             relu_en
    );
        logic signed [DEF_DATA_WIDTH:0] w_ext;
        logic signed [DEF_DATA_WIDTH:0] w_bias;
        logic signed [DEF_DATA_WIDTH:0] w_res;
        w_ext  = {psum[DEF_DATA_WIDTH-1], psum};
        w_bias = '0;
        if (shift != '0) begin
            w_bias = (DEF_DATA_WIDTH+1)'(1) << (shift - SHIFT_WIDTH'(1));
        end
        w_res = (w_ext + w_bias) >>> shift;
        if (relu_en && w_res[DEF_DATA_WIDTH]) begin
            w_res = '0;
        end
        if (w_res > SAT_MAX) begin
            w_res = SAT_MAX;
        end else if (w_res < SAT_MIN) begin
            w_res = SAT_MIN;
        end
        return w_res[DEF_PORT_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_collector_if.sv
`default_nettype none
// ============================================================================
// Module  : psum_collector_if
// Brief   : Skewed psum input lanes and the requantized valid/ready vector
// Revision: 1.0 - initial release
// ============================================================================
interface psum_collector_if
    import lenet_acc_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PORT_WIDTH = DEF_PORT_WIDTH
);
    logic [COLS-1:0]            in_valid;
    logic [COLS*DATA_WIDTH-1:0] in_psum;
    logic                       out_valid;
    logic                       out_ready;
    logic [COLS*PORT_WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_psum,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_psum,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface
`default_nettype wire

// File: rtl/psum_col_fifo.sv
`default_nettype none
// ============================================================================
// Module  : psum_col_fifo
// Brief   : Per-column synchronous FIFO; a full FIFO still accepts on a pop
// Revision: 1.0 - initial release
// ============================================================================
module psum_col_fifo
    import lenet_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    input  wire logic                        clear,
    input  wire logic                        push,
    input  wire logic                        pop,
    input  wire logic [DATA_WIDTH-1:0]       din,
    output logic      [DATA_WIDTH-1:0]       dout,
    output logic                             empty,
    output logic                             full,
    output logic      [$clog2(DEPTH):0]      count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_rd;
    logic                  w_wr;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_rd = pop && !empty && !clear;
    assign w_wr = push && (!full || w_rd) && !clear;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/psum_collector.sv
`default_nettype none
// ============================================================================
// Module  : psum_collector
// Brief   : De-skews column psums into row vectors and requantizes them
// Revision: 1.0 - initial release
// ============================================================================
module psum_collector
    import lenet_acc_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PORT_WIDTH = DEF_PORT_WIDTH,
    parameter int DEPTH      = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   clear,
    input  wire logic [SHIFT_WIDTH-1:0] shift,
    input  wire logic                   relu_en,
    psum_collector_if.slave             bus,
    output logic                        overflow,
    output logic                        busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [COLS-1:0]            w_empty;
    logic [COLS-1:0]            w_full;
    logic [COLS-1:0]            w_pending;
    logic [COLS*DATA_WIDTH-1:0] w_head;
    logic [COLS*PORT_WIDTH-1:0] w_quant;
    logic                       w_row_complete;
    logic                       w_pop;
    logic [COLS-1:0]            w_drop;

    logic                       r_out_valid;
    logic [COLS*PORT_WIDTH-1:0] r_out_data;
    logic                       r_overflow;

    assign w_row_complete = ~|w_empty;
    assign w_pop          = w_row_complete && (!r_out_valid || bus.out_ready) && !clear;
    // A full lane only drops when no pop frees a slot in the same cycle.
    assign w_drop         = bus.in_valid & w_full & ~{COLS{w_pop}};

    generate
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [CW-1:0] w_count;

            psum_col_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (clear),
                .push  (bus.in_valid[c]),
                .pop   (w_pop),
                .din   (bus.in_psum[c*DATA_WIDTH +: DATA_WIDTH]),
                .dout  (w_head[c*DATA_WIDTH +: DATA_WIDTH]),
                .empty (w_empty[c]),
                .full  (w_full[c]),
                .count (w_count)
            );

            assign w_pending[c] = (w_count != '0);
            assign w_quant[c*PORT_WIDTH +: PORT_WIDTH] =
                sat_round(w_head[c*DATA_WIDTH +: DATA_WIDTH], shift, relu_en);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_quant;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign overflow      = r_overflow;
    assign busy          = (|w_pending) || r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_psum_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_psum_collector
// Brief   : Queue-based reference model bench with directed and random rows
// Revision: 1.0 - initial release
// ============================================================================
module tb_psum_collector;
    import lenet_acc_pkg::*;

    localparam int COLS  = 4;
    localparam int DW    = 22;
    localparam int PW    = 9;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [4:0] shift;
    logic       relu_en;
    logic       overflow;
    logic       busy;

    psum_collector_if #(.COLS(COLS), .DATA_WIDTH(DW), .PORT_WIDTH(PW)) bus ();

    psum_collector #(
        .COLS(COLS), .DATA_WIDTH(DW), .PORT_WIDTH(PW), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .shift    (shift),
        .relu_en  (relu_en),
        .bus      (bus),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int quant(input int p, input int sh, input bit relu);
        longint x;
        x = longint'(p);
        if (sh > 0) x = x + (longint'(1) << (sh - 1));
        x = x >>> sh;
        if (relu && x < 0) x = 0;
        if (x > (2 ** (PW-1)) - 1) x = (2 ** (PW-1)) - 1;
        if (x < -(2 ** (PW-1))) x = -(2 ** (PW-1));
        return int'(x);
    endfunction

    function automatic int lane_of(input logic [COLS*PW-1:0] v, input int c);
        logic signed [PW-1:0] x;
        x = v[c*PW +: PW];
        return int'(x);
    endfunction

    function automatic int in_lane(input int c);
        logic signed [DW-1:0] x;
        x = bus.in_psum[c*DW +: DW];
        return int'(x);
    endfunction

    // Reference model: one queue per column plus a single output slot.
    int mq [COLS][$];
    bit m_ov;
    bit m_ovf;
    int m_data [COLS];
    bit m_complete;
    bit m_pop;

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int c = 0; c < COLS; c++) mq[c].delete();
            m_ov  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_complete = 1'b1;
            for (int c = 0; c < COLS; c++) if (mq[c].size() == 0) m_complete = 1'b0;
            m_pop = m_complete && (!m_ov || bus.out_ready);
            if (m_pop) begin
                for (int c = 0; c < COLS; c++)
                    m_data[c] = quant(mq[c].pop_front(), int'(shift), relu_en);
                m_ov = 1'b1;
            end else if (bus.out_ready) begin
                m_ov = 1'b0;
            end
            for (int c = 0; c < COLS; c++) begin
                if (bus.in_valid[c]) begin
                    if (mq[c].size() < DEPTH) mq[c].push_back(in_lane(c));
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    function automatic bit model_busy();
        bit b;
        b = m_ov;
        for (int c = 0; c < COLS; c++) if (mq[c].size() != 0) b = 1'b1;
        return b;
    endfunction

    logic [COLS*PW-1:0] got [$];
    logic [COLS*PW-1:0] prev_data;
    bit                 prev_valid = 1'b0;
    int                 streak = 0;
    int                 max_streak = 0;

    always @(posedge clk) begin
        #1;
        chk("out_valid", bus.out_valid, m_ov);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, model_busy());
        if (m_ov) begin
            for (int c = 0; c < COLS; c++)
                chk($sformatf("out_data[%0d]", c), lane_of(bus.out_data, c), m_data[c]);
        end
        if (rst_n && prev_valid && bus.out_ready) begin
            got.push_back(prev_data);
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
        prev_valid = rst_n && bus.out_valid;
        prev_data  = bus.out_data;
    end

    int rows [32][COLS];

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = '0;
        clear        = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.in_valid = '0;
        clear        = 1'b1;
        @(negedge clk);
        clear        = 1'b0;
    endtask

    // Column c of row r is presented r+c cycles after the first drive.
    task automatic drive_rows(input int n);
        for (int t = 0; t < n + COLS - 1; t++) begin
            @(negedge clk);
            bus.in_valid = '0;
            for (int c = 0; c < COLS; c++) begin
                int r;
                r = t - c;
                if (r >= 0 && r < n) begin
                    bus.in_valid[c]          = 1'b1;
                    bus.in_psum[c*DW +: DW]  = DW'(rows[r][c]);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = '0;
    endtask

    task automatic push_partial();
        @(negedge clk);
        bus.in_valid = 4'b0001;
        bus.in_psum[0 +: DW] = DW'(16);
        @(negedge clk);
        bus.in_valid = 4'b0010;
        bus.in_psum[DW +: DW] = DW'(32);
    endtask

    task automatic check_1234(input string tag);
        got.delete();
        rows[0] = '{16, 32, 48, 64};
        drive_rows(1);
        repeat (3) idle_cycle();
        chk({tag, "_count"}, got.size(), 1);
        if (got.size() == 1)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("%s_lane%0d", tag, c), lane_of(got[0], c), c + 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        shift         = 5'd4;
        relu_en       = 1'b0;
        bus.in_valid  = '0;
        bus.in_psum   = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Skewed row and its latency
        rows[0] = '{160, 320, -48, 8};
        drive_rows(1);
        chk("latency_pre_valid", bus.out_valid, 0);
        @(posedge clk);
        #2;
        chk("latency_valid", bus.out_valid, 1);
        chk("skew_lane0", lane_of(bus.out_data, 0), 10);
        chk("skew_lane1", lane_of(bus.out_data, 1), 20);
        chk("skew_lane2", lane_of(bus.out_data, 2), -3);
        chk("skew_lane3", lane_of(bus.out_data, 3), 1);
        repeat (3) idle_cycle();

        // Saturation, then ReLU
        got.delete();
        rows[0] = '{100000, -100000, -8, 7};
        drive_rows(1);
        repeat (3) idle_cycle();
        chk("sat_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("sat_lane0", lane_of(got[0], 0), 255);
            chk("sat_lane1", lane_of(got[0], 1), -256);
            chk("sat_lane2", lane_of(got[0], 2), 0);
            chk("sat_lane3", lane_of(got[0], 3), 0);
        end
        relu_en = 1'b1;
        got.delete();
        drive_rows(1);
        repeat (3) idle_cycle();
        chk("relu_count", got.size(), 1);
        if (got.size() == 1) begin
            chk("relu_lane0", lane_of(got[0], 0), 255);
            chk("relu_lane1", lane_of(got[0], 1), 0);
        end
        relu_en = 1'b0;

        // Backpressure: six rows into DEPTH+1 storage
        bus.out_ready = 1'b0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < COLS; c++) rows[r][c] = (r + 1) * 16;
        got.delete();
        drive_rows(6);
        repeat (2) idle_cycle();
        chk("bp_overflow", overflow, 1);
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_lane0", lane_of(bus.out_data, 0), 1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        max_streak    = 0;
        repeat (8) idle_cycle();
        chk("bp_count", got.size(), 5);
        chk("bp_streak", max_streak, 5);
        for (int i = 0; i < got.size(); i++)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("bp_row%0d_lane%0d", i, c), lane_of(got[i], c), i + 1);
        chk("bp_overflow_sticky", overflow, 1);

        // Streaming
        pulse_clear();
        chk("clear_overflow", overflow, 0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < COLS; c++)
                rows[r][c] = (r % 2 == 0) ? int'($urandom_range(0, 8000)) - 4000
                                          : int'($urandom_range(0, 4194303)) - 2097152;
        got.delete();
        max_streak = 0;
        drive_rows(16);
        repeat (4) idle_cycle();
        chk("stream_count", got.size(), 16);
        chk("stream_streak", max_streak, 16);
        chk("stream_overflow", overflow, 0);
        for (int i = 0; i < got.size(); i++)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("stream_row%0d_lane%0d", i, c), lane_of(got[i], c),
                    quant(rows[i][c], 4, 1'b0));

        // Mid-row flush by clear
        push_partial();
        @(negedge clk);
        bus.in_valid = '0;
        chk("flush_busy_before", busy, 1);
        clear = 1'b1;
        @(posedge clk);
        #2;
        chk("flush_busy_after", busy, 0);
        @(negedge clk);
        clear = 1'b0;
        check_1234("flush_clear");

        // Mid-row flush by reset
        push_partial();
        @(negedge clk);
        bus.in_valid = '0;
        rst_n        = 1'b0;
        #1;
        chk("rst_busy_after", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_1234("flush_rst");

        // Random traffic with random ready, sparse clears, varied shift/relu
        for (int seg = 0; seg < 3; seg++) begin
            pulse_clear();
            shift   = 5'($urandom_range(0, 21));
            relu_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                for (int c = 0; c < COLS; c++) begin
                    bus.in_valid[c] = ($urandom_range(0, 9) < 7);
                    bus.in_psum[c*DW +: DW] = DW'(int'($urandom_range(0, 4194303)) - 2097152);
                end
                bus.out_ready = (seg == 1) ? ($urandom_range(0, 3) == 0)
                                           : ($urandom_range(0, 3) != 0);
                clear = ($urandom_range(0, 63) == 0);
            end
            @(negedge clk);
            bus.in_valid  = '0;
            clear         = 1'b0;
            bus.out_ready = 1'b1;
            repeat (8) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/psum_collector.md
# psum_collector

Drains partial sums from the bottom edge of the weight-stationary PE systolic array. Each column's result arrives time-skewed: column c lags column 0 by c cycles. The collector buffers each column independently and re-aligns the results into one row vector. It then requantizes every element to the PORT_WIDTH activation format (rounding shift, optional ReLU, saturation) and emits the vector on a valid/ready stream toward the activation buffer feeding the next layer.

## Interface
- COLS, 4: array columns (number of vector lanes)
- DATA_WIDTH, 22: signed partial-sum width (PE b_out width)
- PORT_WIDTH, 9: signed output activation width (PE a/weight width)
- DEPTH, 4: per-column FIFO depth; power of two, ≥ COLS
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset; clears all state
- clear  in  1  synchronous flush: empties FIFOs, drops the output register, clears overflow
- shift  in  5  requant right-shift amount, 0..DATA_WIDTH-1; must be static while busy
- relu_en  in  1  clamp negative results to 0
- in_valid  in  COLS  per-column strobe; bit c qualifies column c's psum
- in_psum  in  COLS*DATA_WIDTH  signed psums; column c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer accepts when high together with out_valid
- out_data  out  COLS*PORT_WIDTH  signed requantized vector; same lane packing as in_psum
- overflow  out  1  sticky flag: a psum was dropped because its column FIFO was full
- busy  out  1  high while any FIFO is non-empty or out_valid is high

## Operation
- Push: when in_valid[c]=1, in_psum lane c is written to FIFO c.
  - The write is accepted if count_c < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the value is dropped, overflow is set, and the other lanes are unaffected.
  - The array cannot stall, so there is no input ready.
- Row complete: all COLS FIFO heads are non-empty.
- Pop condition: row complete AND (out_valid=0 OR out_ready=1).
  - On a pop, all FIFOs pop together and the quantized heads load into out_data.
- Requant per lane:
  - Rounding: r = (psum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift. Compute in DATA_WIDTH+1 bits so the rounding add cannot wrap. This is an arithmetic shift, so negative values round toward +inf at the .5 point.
  - ReLU: if relu_en=1 and r<0, r=0.
  - Saturation: clamp r to [-2^(PORT_WIDTH-1), 2^(PORT_WIDTH-1)-1], i.e. [-256, 255] at the defaults.
- Output: out_valid clears on handshake unless a new pop reloads it in the same cycle.
- Row order: rows emerge strictly in arrival order per lane, with no reordering.
- clear has priority over push and pop in the same cycle.
- overflow is cleared only by clear or rst_n.

## Timing
- Reset values: out_valid=0, out_data=0, overflow=0, busy=0, all FIFO counts 0.
- Latency: last column pushed at edge t → out_valid=1 after edge t+1.
  - With the standard skew, this is COLS cycles after column 0's push.
- Throughput: one vector per cycle when rows arrive every cycle and out_ready is held at 1.
- Backpressure: out_data and out_valid are held stable while out_valid=1 and out_ready=0.
- Storage: DEPTH rows in the FIFOs plus one in the output register before any drop.
- Full FIFO with simultaneous push and pop: both succeed and the count is unchanged. No overflow.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Reset mid-row: asserting rst_n low at any cycle discards partial rows immediately (asynchronous). The first full row after release is emitted correctly.

## Structure
- Shared package lenet_acc_pkg holds:
  - DATA_WIDTH=22 and PORT_WIDTH=9 defaults
  - the saturation bound constants
  - a sat_round function, shared with any future requant stage
- Sub-module psum_col_fifo: one synchronous FIFO per column, generate-instantiated COLS times.
  - Ports: push, pop, din, dout, empty, full, count.
- The top level holds the row-complete logic, the requant, the output register and overflow.

## Test plan
All scenarios use COLS=4, DEPTH=4, shift=4.
- Reset: hold rst_n=0 → out_valid=0, out_data=0, overflow=0, busy=0.
- Skewed row:
  - Stimulus: psums 160, 320, -48, 8 on columns 0..3 at cycles 0..3.
  - Response: out_valid=1 after edge 4, lanes 10, 20, -3, 1.
- Saturation and ReLU:
  - Stimulus: psums 100000, -100000, -8, 7 with relu_en=0 → lanes 255, -256, 0, 0.
  - The same row with relu_en=1 → lanes 255, 0, 0, 0.
- Backpressure and overflow:
  - Hold out_ready=0 and push 6 complete rows 1..6 → overflow=1, and row 6 is dropped on every lane.
  - Release ready → rows 1..5 emerge in order, one per cycle.
- Streaming: 16 back-to-back skewed rows with out_ready=1 → 16 consecutive out_valid cycles, values match, overflow=0.
- Mid-row flush:
  - Stimulus: after columns 0..1 of a row are pushed, pulse clear (then repeat the test with rst_n low).
  - Response: busy=0 on the next cycle, and a following full row 16, 32, 48, 64 emits 1, 2, 3, 4.
